// File: rtl/slm_frame_fetch.sv
// slm_frame_fetch: vblank-synchronised frame selection and per-line burst reads for the SLM VGA path.
// Define SLM_FRAME_FETCH_UNDERRUN_CNT_EN to build the saturating underrun counter on oUNDERRUN_CNT.
module slm_frame_fetch #(
  parameter int LINE_WORDS  = 480,
  parameter int NUM_LINES   = 1080,
  parameter int BURST_LEN   = 32,
  parameter int STRIDE_LOG2 = 20
) (
  input  logic                   iCLK,
  input  logic                   iRST,
  input  logic [5:0]             iFRAME_ID,
  input  logic                   iVGA_VBLANK,
  input  logic                   iLINE_REQ,
  output logic                   oRD_REQ,
  output logic [STRIDE_LOG2+5:0] oRD_ADDR,
  output logic [8:0]             oRD_LEN,
  input  logic                   iRD_ACK,
  output logic                   oLINE_DONE,
  output logic                   oFRAME_SYNC,
  output logic [5:0]             oACTIVE_FRAME_ID,
  output logic                   oUNDERRUN,
  output logic [15:0]            oUNDERRUN_CNT
);
  localparam int AW  = STRIDE_LOG2 + 6;
  localparam int BPL = LINE_WORDS / BURST_LEN;
  localparam int LW  = $clog2(NUM_LINES + 1);
  localparam int BW  = $clog2(BPL + 1);

  typedef enum logic [2:0] {ST_IDLE, ST_WAIT_LINE, ST_BURST, ST_LINE_DONE, ST_RESTART} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   ptr_q, ptr_d;
  logic [LW-1:0]   line_cnt_q, line_cnt_d;
  logic [BW-1:0]   burst_cnt_q, burst_cnt_d;
  logic            rd_req_q, rd_req_d;
  logic            line_done_q, line_done_d;
  logic [5:0]      frame_id_q, frame_id_d;
  logic            underrun_q, underrun_d;
  logic [8:0]      rd_len_q;
  logic            vb_m_q, vb_s_q, frame_sync_q;
  logic            vb_rise, hold, underrun_ev;

  assign vb_rise = vb_s_q & ~frame_sync_q;
  assign hold    = rd_req_q & ~iRD_ACK;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    line_cnt_d  = line_cnt_q;
    burst_cnt_d = burst_cnt_q;
    rd_req_d    = rd_req_q;
    line_done_d = 1'b0;
    frame_id_d  = frame_id_q;
    underrun_ev = 1'b0;
    if (vb_rise && hold) begin
      frame_id_d = iFRAME_ID;
      state_d    = ST_RESTART;
    end else if (vb_rise || (state_q == ST_RESTART && iRD_ACK)) begin
      frame_id_d  = vb_rise ? iFRAME_ID : frame_id_q;
      ptr_d       = {frame_id_d, {STRIDE_LOG2{1'b0}}};
      line_cnt_d  = '0;
      burst_cnt_d = '0;
      rd_req_d    = 1'b0;
      state_d     = ST_WAIT_LINE;
    end else begin
      underrun_ev = iLINE_REQ && (state_q inside {ST_BURST, ST_LINE_DONE, ST_RESTART});
      case (state_q)
        ST_WAIT_LINE: if (iLINE_REQ && line_cnt_q < LW'(NUM_LINES)) begin
          state_d  = ST_BURST;
          rd_req_d = 1'b1;
        end
        ST_BURST: if (!rd_req_q) rd_req_d = 1'b1;
        else if (iRD_ACK) begin
          ptr_d       = ptr_q + AW'(BURST_LEN);
          burst_cnt_d = burst_cnt_q + BW'(1);
          rd_req_d    = 1'b0;
          if (burst_cnt_q == BW'(BPL - 1)) begin
            state_d     = ST_LINE_DONE;
            line_done_d = 1'b1;
          end
        end
        ST_LINE_DONE: begin
          line_cnt_d  = line_cnt_q + LW'(1);
          burst_cnt_d = '0;
          state_d     = ST_WAIT_LINE;
        end
        default: ;
      endcase
    end
    underrun_d = underrun_q | underrun_ev;
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_q      <= ST_IDLE;
      ptr_q        <= '0;
      line_cnt_q   <= '0;
      burst_cnt_q  <= '0;
      rd_req_q     <= 1'b0;
      line_done_q  <= 1'b0;
      frame_id_q   <= '0;
      underrun_q   <= 1'b0;
      rd_len_q     <= '0;
      vb_m_q       <= 1'b0;
      vb_s_q       <= 1'b0;
      frame_sync_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      line_cnt_q   <= line_cnt_d;
      burst_cnt_q  <= burst_cnt_d;
      rd_req_q     <= rd_req_d;
      line_done_q  <= line_done_d;
      frame_id_q   <= frame_id_d;
      underrun_q   <= underrun_d;
      rd_len_q     <= 9'(BURST_LEN);
      vb_m_q       <= iVGA_VBLANK;
      vb_s_q       <= vb_m_q;
      frame_sync_q <= vb_s_q;
    end
  end

`ifdef SLM_FRAME_FETCH_UNDERRUN_CNT_EN
  logic [15:0] ucnt_q, ucnt_d;
  assign ucnt_d = ucnt_q + 16'(underrun_ev && ~&ucnt_q);
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) ucnt_q <= '0;
    else ucnt_q <= ucnt_d;
  end
  assign oUNDERRUN_CNT = ucnt_q;
`else
  assign oUNDERRUN_CNT = '0;
`endif

  assign oRD_REQ          = rd_req_q;
  assign oRD_ADDR         = ptr_q;
  assign oRD_LEN          = rd_len_q;
  assign oLINE_DONE       = line_done_q;
  assign oFRAME_SYNC      = frame_sync_q;
  assign oACTIVE_FRAME_ID = frame_id_q;
  assign oUNDERRUN        = underrun_q;
endmodule

// File: tb/tb_slm_frame_fetch.sv
// tb_slm_frame_fetch: scenario tasks against slm_frame_fetch with an expected-burst-address queue.
module tb_slm_frame_fetch;
  logic        clk = 1'b0, rst = 1'b1;
  logic [5:0]  frame_id = '0;
  logic        vblank = 1'b0, line_req = 1'b0, ack = 1'b0;
  logic        rd_req, line_done, frame_sync, underrun;
  logic [25:0] rd_addr;
  logic [8:0]  rd_len;
  logic [5:0]  active_id;
  logic [15:0] underrun_cnt;
  int vectors = 0, errors = 0, ld_cnt = 0;
  logic [25:0] exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) if (line_done) ld_cnt++;

  slm_frame_fetch #(.LINE_WORDS(64), .NUM_LINES(2), .BURST_LEN(32), .STRIDE_LOG2(20)) dut (
    .iCLK(clk), .iRST(rst), .iFRAME_ID(frame_id), .iVGA_VBLANK(vblank), .iLINE_REQ(line_req),
    .oRD_REQ(rd_req), .oRD_ADDR(rd_addr), .oRD_LEN(rd_len), .iRD_ACK(ack), .oLINE_DONE(line_done),
    .oFRAME_SYNC(frame_sync), .oACTIVE_FRAME_ID(active_id), .oUNDERRUN(underrun),
    .oUNDERRUN_CNT(underrun_cnt)
  );

  task automatic pulse_line;
    @(negedge clk) line_req = 1'b1;
    @(negedge clk) line_req = 1'b0;
  endtask

  task automatic pulse_vblank(input logic [5:0] id);
    @(negedge clk) begin frame_id = id; vblank = 1'b1; end
    repeat (6) @(negedge clk);
    vblank = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  // memory responder: pops the expected address per burst and acks three cycles after it appears
  task automatic serve(input int n);
    for (int b = 0; b < n; b++) begin
      int t = 0;
      logic [25:0] exp;
      while (!rd_req && t < 50) begin @(negedge clk); t++; end
      vectors++;
      if (rd_req !== 1'b1) begin errors++; $display("FAIL req_timeout got=%0b want=1", rd_req); end
      exp = '0;
      vectors++;
      if (exp_q.size() == 0) begin errors++; $display("FAIL scoreboard_empty got=%h want=<queued>", rd_addr); end
      else begin
        exp = exp_q.pop_front();
        if (rd_addr !== exp) begin errors++; $display("FAIL burst_addr got=%h want=%h", rd_addr, exp); end
      end
      repeat (2) @(negedge clk);
      vectors++;
      if (rd_req !== 1'b1 || rd_addr !== exp) begin errors++; $display("FAIL req_held got=%0b/%h want=1/%h", rd_req, rd_addr, exp); end
      ack = 1'b1;
      @(negedge clk) ack = 1'b0;
    end
  endtask

  task automatic no_req_window(input string name);
    logic seen = 1'b0;
    repeat (10) @(negedge clk) seen |= rd_req;
    vectors++;
    if (seen !== 1'b0) begin errors++; $display("FAIL %s got=%0b want=0", name, seen); end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    vectors++;
    if ({rd_req, rd_addr, rd_len, line_done, frame_sync, active_id, underrun, underrun_cnt} !== '0) begin
      errors++; $display("FAIL reset_outputs got=%0b/%h/%0d/%0b/%0b/%0d/%0b/%0d want=all0",
        rd_req, rd_addr, rd_len, line_done, frame_sync, active_id, underrun, underrun_cnt);
    end
    rst = 1'b0;
    pulse_line();
    no_req_window("idle_line_req");
    vectors++;
    if (underrun !== 1'b0 || rd_len !== 9'd32) begin errors++; $display("FAIL idle_state got=%0b/%0d want=0/32", underrun, rd_len); end
  endtask

  task automatic test_sync_latency;
    @(negedge clk) begin frame_id = 6'd5; vblank = 1'b1; end
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      vectors++;
      if (frame_sync !== (i == 3)) begin errors++; $display("FAIL sync_latency_%0d got=%0b want=%0b", i, frame_sync, i == 3); end
    end
    repeat (3) @(negedge clk);
    vblank = 1'b0;
    repeat (4) @(negedge clk);
    vectors++;
    if (active_id !== 6'd5 || frame_sync !== 1'b0) begin errors++; $display("FAIL frame_latch got=%0d/%0b want=5/0", active_id, frame_sync); end
  endtask

  task automatic test_line_fetch;
    int ld0 = ld_cnt;
    exp_q.push_back(26'h500000); exp_q.push_back(26'h500020);
    pulse_line();
    serve(2);
    repeat (3) @(negedge clk);
    vectors++;
    if (ld_cnt - ld0 !== 1) begin errors++; $display("FAIL line_done_1 got=%0d want=1", ld_cnt - ld0); end
    exp_q.push_back(26'h500040); exp_q.push_back(26'h500060);
    pulse_line();
    serve(2);
    repeat (3) @(negedge clk);
    vectors++;
    if (ld_cnt - ld0 !== 2) begin errors++; $display("FAIL line_done_2 got=%0d want=2", ld_cnt - ld0); end
  endtask

  task automatic test_num_lines_and_switch;
    int ld0;
    pulse_line();
    no_req_window("line_limit");
    vectors++;
    if (underrun !== 1'b0) begin errors++; $display("FAIL limit_no_underrun got=%0b want=0", underrun); end
    frame_id = 6'd9;
    repeat (5) @(negedge clk);
    vectors++;
    if (active_id !== 6'd5) begin errors++; $display("FAIL midframe_id got=%0d want=5", active_id); end
    pulse_vblank(6'd9);
    vectors++;
    if (active_id !== 6'd9) begin errors++; $display("FAIL new_frame_id got=%0d want=9", active_id); end
    ld0 = ld_cnt;
    exp_q.push_back(26'h900000); exp_q.push_back(26'h900020);
    pulse_line();
    serve(2);
    repeat (3) @(negedge clk);
    vectors++;
    if (ld_cnt - ld0 !== 1) begin errors++; $display("FAIL frame9_line got=%0d want=1", ld_cnt - ld0); end
  endtask

  task automatic test_restart_pending;
    int ld0, t = 0, bad = 0;
    pulse_vblank(6'd5);
    exp_q.push_back(26'h500000);
    pulse_line();
    serve(1);
    while (!rd_req && t < 50) begin @(negedge clk); t++; end
    vectors++;
    if (rd_req !== 1'b1 || rd_addr !== 26'h500020) begin errors++; $display("FAIL pending_req got=%0b/%h want=1/500020", rd_req, rd_addr); end
    ld0 = ld_cnt;
    frame_id = 6'd7; vblank = 1'b1;
    repeat (8) @(negedge clk) if (rd_req !== 1'b1 || rd_addr !== 26'h500020) bad++;
    vectors++;
    if (bad != 0) begin errors++; $display("FAIL restart_hold got=%0d_bad_cycles want=0", bad); end
    ack = 1'b1;
    @(negedge clk) ack = 1'b0;
    vectors++;
    if (rd_req !== 1'b0 || active_id !== 6'd7) begin errors++; $display("FAIL restart_after_ack got=%0b/%0d want=0/7", rd_req, active_id); end
    vblank = 1'b0;
    repeat (4) @(negedge clk);
    vectors++;
    if (ld_cnt !== ld0 || rd_req !== 1'b0) begin errors++; $display("FAIL aborted_line got=%0d/%0b want=%0d/0", ld_cnt, rd_req, ld0); end
    exp_q.push_back(26'h700000); exp_q.push_back(26'h700020);
    pulse_line();
    serve(2);
    repeat (3) @(negedge clk);
    vectors++;
    if (ld_cnt - ld0 !== 1) begin errors++; $display("FAIL restart_line got=%0d want=1", ld_cnt - ld0); end
  endtask

  task automatic test_underrun;
    int ld0 = ld_cnt;
    logic [15:0] exp_cnt;
`ifdef SLM_FRAME_FETCH_UNDERRUN_CNT_EN
    exp_cnt = 16'd3;
`else
    exp_cnt = 16'd0;
`endif
    exp_q.push_back(26'h700040); exp_q.push_back(26'h700060);
    pulse_line();
    repeat (3) pulse_line();
    vectors++;
    if (underrun !== 1'b1 || underrun_cnt !== exp_cnt) begin errors++; $display("FAIL underrun got=%0b/%0d want=1/%0d", underrun, underrun_cnt, exp_cnt); end
    serve(2);
    repeat (3) @(negedge clk);
    vectors++;
    if (ld_cnt - ld0 !== 1) begin errors++; $display("FAIL underrun_line got=%0d want=1", ld_cnt - ld0); end
    pulse_vblank(6'd3);
    vectors++;
    if (underrun !== 1'b1 || underrun_cnt !== exp_cnt) begin errors++; $display("FAIL underrun_sticky got=%0b/%0d want=1/%0d", underrun, underrun_cnt, exp_cnt); end
  endtask

  task automatic test_reset_midburst;
    int t = 0;
    pulse_line();
    while (!rd_req && t < 50) begin @(negedge clk); t++; end
    vectors++;
    if (rd_req !== 1'b1 || rd_addr !== 26'h300000) begin errors++; $display("FAIL pre_reset_req got=%0b/%h want=1/300000", rd_req, rd_addr); end
    #2 rst = 1'b1;
    #1;
    vectors++;
    if ({rd_req, rd_addr, rd_len, line_done, frame_sync, active_id, underrun, underrun_cnt} !== '0) begin
      errors++; $display("FAIL async_reset got=%0b/%h/%0d/%0b/%0d/%0b/%0d want=all0",
        rd_req, rd_addr, rd_len, line_done, active_id, underrun, underrun_cnt);
    end
    @(negedge clk) rst = 1'b0;
    pulse_line();
    no_req_window("post_reset_idle");
    pulse_vblank(6'd3);
    exp_q.push_back(26'h300000); exp_q.push_back(26'h300020);
    pulse_line();
    serve(2);
    vectors++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_left got=%0d want=0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_sync_latency();
    test_line_fetch();
    test_num_lines_and_switch();
    test_restart_pending();
    test_underrun();
    test_reset_midburst();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/slm_frame_fetch.md
Name: slm_frame_fetch

Overview:
- Memory-read front end for the SLM VGA display path. Sits between the frame-timing generator/line buffer and the SDRAM read port, directly upstream of the display sequencer.
- Selects the stored SLM image named by the sequencer's current frame ID, switching only at vertical blank so frames never tear.
- Issues burst read requests line by line.
- Returns a clean, synchronised frame-sync level to the sequencer.

Parameters:
- LINE_WORDS, 480, memory words per displayed line; must be an integer multiple of BURST_LEN.
- NUM_LINES, 1080, active lines per frame.
- BURST_LEN, 32, words per read burst; power of two, at most 256.
- STRIDE_LOG2, 20, log2 of the word stride between stored frames.

Ports:
- iCLK  in  1  system clock, 50 MHz.
- iRST  in  1  reset, asynchronous, active-high.
- iFRAME_ID  in  6  requested frame, from the sequencer's current-display-frame output.
- iVGA_VBLANK  in  1  vertical blank level from the timing generator; asynchronous to iCLK domain logic.
- iLINE_REQ  in  1  one-cycle pulse: line buffer wants the next line.
- oRD_REQ  out  1  read burst request; held until acknowledged.
- oRD_ADDR  out  STRIDE_LOG2+6  word address of the burst.
- oRD_LEN  out  9  burst length; constant BURST_LEN.
- iRD_ACK  in  1  memory accepted the request this cycle.
- oLINE_DONE  out  1  one-cycle pulse when all bursts of a line are accepted.
- oFRAME_SYNC  out  1  synchronised vblank level, to the sequencer's frame-sync input.
- oACTIVE_FRAME_ID  out  6  frame currently being fetched.
- oUNDERRUN  out  1  sticky: a line request arrived while busy.
- oUNDERRUN_CNT  out  16  underrun count (optional feature).

Behaviour:
- Reset values: all outputs 0; state ST_IDLE; line_cnt 0; burst_cnt 0; base address 0.
- Synchroniser: iVGA_VBLANK passes through a 2-flop synchroniser to give vb_s. oFRAME_SYNC = vb_s, registered. Latency is 2 cycles (3 to oFRAME_SYNC). Rising edge of vb_s = vb_rise, a 1-cycle strobe.
- On vb_rise, from any state:
  - latch iFRAME_ID into oACTIVE_FRAME_ID;
  - ptr <= {iFRAME_ID, STRIDE_LOG2 zero bits};
  - line_cnt <= 0; burst_cnt <= 0;
  - next state ST_WAIT_LINE.
  - Exception: if oRD_REQ is high and unacknowledged, it stays asserted with an unchanged address until iRD_ACK. The restart is applied the cycle after the ack, using the frame ID latched at vb_rise.
- States:
  - ST_IDLE -> ST_WAIT_LINE on first vb_rise.
  - ST_WAIT_LINE: on iLINE_REQ with line_cnt < NUM_LINES -> ST_BURST. On iLINE_REQ with line_cnt == NUM_LINES, ignore the request and stay.
  - ST_BURST: oRD_REQ=1, oRD_ADDR=ptr. On iRD_ACK: ptr += BURST_LEN, burst_cnt += 1. If burst_cnt was LINE_WORDS/BURST_LEN-1 -> ST_LINE_DONE, else stay in ST_BURST; oRD_REQ drops for one cycle between bursts.
  - ST_LINE_DONE: oLINE_DONE=1 for 1 cycle; line_cnt += 1; burst_cnt <= 0; -> ST_WAIT_LINE.
  - ST_RESTART (internal): holds a vb_rise deferred by a pending handshake; -> ST_WAIT_LINE after the ack.
- Underrun: iLINE_REQ in ST_BURST, ST_LINE_DONE or ST_RESTART sets oUNDERRUN. The request is dropped, not queued. oUNDERRUN clears only on reset.
- ptr wraps modulo 2^(STRIDE_LOG2+6). Within-frame addresses never cross the stride when LINE_WORDS*NUM_LINES ≤ 2^STRIDE_LOG2. Exceeding this is a configuration error and is not checked.
- iFRAME_ID changes mid-frame have no effect until the next vb_rise.
- Simultaneous vb_rise and iLINE_REQ: vb_rise wins; the line request is ignored and is not counted as an underrun.
- Reset mid-burst: oRD_REQ drops immediately (asynchronous). The memory side must tolerate an abandoned request.

Optional Feature:
- Macro: SLM_FRAME_FETCH_UNDERRUN_CNT_EN.
- Defined: oUNDERRUN_CNT is a 16-bit counter, saturating at 0xFFFF. It increments on each underrun event and clears on reset only.
- Undefined: oUNDERRUN_CNT is tied to 0 and no counter logic is built; oUNDERRUN is unaffected.

Test Plan:
- Defaults with BURST_LEN=32, LINE_WORDS=64; iFRAME_ID=5, vblank pulse, then one iLINE_REQ, ack each request after 3 cycles -> bursts at 0x500000 and 0x500020; oLINE_DONE pulses once; a second line starts at 0x500040.
- iFRAME_ID changed 5->9 mid-frame -> oACTIVE_FRAME_ID stays 5 until the next vblank rise, then becomes 9 and the next burst is at 0x900000.
- Vblank rises while oRD_REQ is pending at 0x500020 -> request held until ack, then the first burst after restart is at the new frame base; no oLINE_DONE for the aborted line.
- iLINE_REQ during ST_BURST, three times -> oUNDERRUN=1; with the macro defined, oUNDERRUN_CNT=3; line fetch continues unaffected.
- NUM_LINES=2: third iLINE_REQ before vblank -> no oRD_REQ, no underrun; after the next vblank, fetching resumes at line 0.
- Reset asserted mid-burst -> all outputs 0 asynchronously; after release, no requests until the first vblank rise.
